xlgmii_tx_packet_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 128-bit XLGMII transmit bridge between `NUM_PORTS` AXI4-Stream packet sources (e.g. tag-data framer, control/ARP responder). Grant is held for a whole packet, so beats of different packets never interleave at the bridge. Output passes through a 2-entry skid buffer, so the bridge sees full-throughput, bubble-free packets. Sits directly upstream of the XLGMII TX bridge in the QSFP transmit path.

---
 rtl/xlgmii_tx_arb_pkg.sv | 5 +
 rtl/axis_skid_buffer.sv | 48 ++++
 rtl/xlgmii_tx_packet_arbiter.sv | 107 ++++++++++
 tb/tb_xlgmii_tx_packet_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xlgmii_tx_arb_pkg.sv
// xlgmii_tx_arb_pkg: shared types and limits for the XLGMII TX packet arbiter
package xlgmii_tx_arb_pkg;
  localparam int ARB_MAX_PORTS = 8;
  typedef enum logic [0:0] {ARB_IDLE = 1'b0, ARB_PACKET = 1'b1} arb_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry AXI4-Stream slice with registered ready and registered outputs
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [KEEP_WIDTH-1:0] out_keep,
  output logic                  out_last
);
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [KEEP_WIDTH-1:0] skid_keep;
  logic                  skid_last;
  logic                  push;
  logic                  load;
  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign load     = !out_valid || out_ready;
  // output register refills from the skid entry first; skid only catches a beat during a stall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
    end else if (load) begin
      out_valid  <= skid_valid || push;
      skid_valid <= 1'b0;
      if (skid_valid) {out_data, out_keep, out_last} <= {skid_data, skid_keep, skid_last};
      else if (push) {out_data, out_keep, out_last} <= {in_data, in_keep, in_last};
    end else if (push) begin
      skid_valid <= 1'b1;
      {skid_data, skid_keep, skid_last} <= {in_data, in_keep, in_last};
    end
endmodule

// File: rtl/xlgmii_tx_packet_arbiter.sv
// xlgmii_tx_packet_arbiter: packet-granular round-robin mux of AXI4-Stream sources onto the XLGMII TX bridge
module xlgmii_tx_packet_arbiter
  import xlgmii_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic [KEEP_WIDTH-1:0]           m_tkeep,
  output logic                            m_tlast,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            err_tlast_tkeep,
  output logic                            err_underrun
);
  localparam int PW = $clog2(NUM_PORTS);
  if (DATA_WIDTH != 128) begin : g_width_chk
    $error("xlgmii_tx_packet_arbiter: DATA_WIDTH must be 128");
  end
  if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_ports_chk
    $error("xlgmii_tx_packet_arbiter: NUM_PORTS must be 2..8");
  end
  arb_state_t            state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         winner;
  logic [PW-1:0]         cand;
  logic [PW-1:0]         sel;
  logic                  found;
  logic                  sel_valid;
  logic                  in_ready;
  logic                  acc;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_last;
  // first valid port after the last-served one, wrapping modulo NUM_PORTS
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!found && s_tvalid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end
  assign sel       = state == ARB_PACKET ? gnt_idx : winner;
  assign sel_valid = state == ARB_PACKET ? s_tvalid[sel] : found;
  assign acc       = sel_valid && in_ready;
  assign sel_data  = s_tdata[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_tkeep[int'(sel) * KEEP_WIDTH +: KEEP_WIDTH];
  assign sel_last  = s_tlast[sel];
  assign s_tready  = (rst || !in_ready || (state == ARB_IDLE && !found)) ? '0 : NUM_PORTS'(1) << sel;
  assign grant     = state == ARB_PACKET ? NUM_PORTS'(1) << gnt_idx : '0;
  // packet ownership: single-beat packets never leave IDLE, multi-beat ones hold grant until tlast
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= ARB_IDLE;
      rr_ptr  <= PW'(NUM_PORTS - 1);
      gnt_idx <= '0;
    end else if (acc) begin
      if (sel_last) begin
        state  <= ARB_IDLE;
        rr_ptr <= sel;
      end else if (state == ARB_IDLE) begin
        state   <= ARB_PACKET;
        gnt_idx <= winner;
      end
    end
  // protocol error pulses, one per offending cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_tlast_tkeep <= 1'b0;
      err_underrun    <= 1'b0;
    end else begin
      err_tlast_tkeep <= acc && sel_last && sel_keep == '0;
      err_underrun    <= state == ARB_PACKET && !s_tvalid[gnt_idx];
    end
  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (sel_valid),
    .in_ready (in_ready),
    .in_data  (sel_data),
    .in_keep  (sel_keep),
    .in_last  (sel_last),
    .out_valid(m_tvalid),
    .out_ready(m_tready),
    .out_data (m_tdata),
    .out_keep (m_tkeep),
    .out_last (m_tlast)
  );
endmodule

// File: tb/tb_xlgmii_tx_packet_arbiter.sv
// tb_xlgmii_tx_packet_arbiter: directed self-checking bench for the XLGMII TX packet arbiter
module tb_xlgmii_tx_packet_arbiter;
  localparam int NP = 4;
  typedef logic [144:0] beat_t;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tready;
  logic [NP*128-1:0] s_tdata = '0;
  logic [NP*16-1:0]  s_tkeep = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [127:0]      m_tdata;
  logic [15:0]       m_tkeep;
  logic              m_tlast;
  logic [NP-1:0]     grant;
  logic              err_tlast_tkeep;
  logic              err_underrun;
  int total = 0;
  int bad = 0;
  beat_t mem [NP][64];
  int gap [NP][64];
  int wr [NP] = '{default: 0};
  int rd [NP] = '{default: 0};
  int gcnt [NP] = '{default: 0};
  logic [NP-1:0] acc = '0;
  beat_t out_b [256];
  int out_c [256];
  int on = 0;
  int in_c [256];
  logic [NP-1:0] in_g [256];
  int inn = 0;
  int cyc = 0;
  int n_und = 0;
  int n_tk = 0;
  int n_gnz = 0;
  int n_hold0 = 0;
  logic [145:0] pv = '0;
  logic stall = 1'b0;

  xlgmii_tx_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .grant(grant), .err_tlast_tkeep(err_tlast_tkeep), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int p, input int n, input int b);
    return {104'(0), 8'(p), 8'(n), 8'(b)};
  endfunction

  // source model: queued beats per port, optional invalid cycles before a beat
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        rd[p]++;
        gcnt[p] = gap[p][rd[p]];
      end else if (gcnt[p] > 0) gcnt[p]--;
      s_tvalid[p] = rd[p] < wr[p] && gcnt[p] == 0;
      {s_tdata[p*128 +: 128], s_tkeep[p*16 +: 16], s_tlast[p]} = mem[p][rd[p]];
    end
  end

  // monitor on the inactive edge: handshakes, stability under backpressure, error pulses
  always @(negedge clk) begin
    acc = s_tvalid & s_tready;
    chk("ready_onehot", $countones(s_tready) <= 1, 1);
    if (stall) chk("hold_stable", {m_tvalid, m_tdata, m_tkeep, m_tlast}, pv);
    stall = m_tvalid && !m_tready;
    pv = {m_tvalid, m_tdata, m_tkeep, m_tlast};
    if (m_tvalid && m_tready) begin
      out_b[on] = {m_tdata, m_tkeep, m_tlast};
      out_c[on] = cyc;
      on++;
    end
    for (int p = 0; p < NP; p++)
      if (acc[p]) begin
        in_c[inn] = cyc;
        in_g[inn] = grant;
        inn++;
      end
    n_und += int'(err_underrun);
    n_tk += int'(err_tlast_tkeep);
    n_gnz += int'(grant != '0);
    n_hold0 += int'(!s_tvalid[0] && grant == 4'b0001);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(input int p, input int n, input int len, input logic [15:0] klast, input int gpos, input int glen);
    for (int b = 0; b < len; b++) begin
      mem[p][wr[p]] = {mk(p, n, b), (b == len - 1) ? klast : 16'hFFFF, b == len - 1};
      gap[p][wr[p]] = (b == gpos) ? glen : 0;
      wr[p]++;
    end
  endtask

  task automatic wait_out(input int target, input int budget);
    int t = 0;
    while (on < target && t < budget) begin
      step(1);
      t++;
    end
    chk("out_timeout", on >= target, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    for (int p = 0; p < NP; p++) wr[p] = rd[p];
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int base;
    int ib;
    int t;
    int k;
    int r0;
    int u0;
    int k0;
    int h0;
    int g0;
    logic [15:0] pat = 16'b0011_0110_1001_1100;
    // reset: a waiting source must still see ready low
    load(0, 9, 1, 16'hFFFF, -1, 0);
    step(3);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    do_reset();
    chk("idle_m_tvalid", m_tvalid, 0);
    chk("idle_m_tdata", m_tdata, 0);
    chk("idle_m_tkeep", m_tkeep, 0);
    chk("idle_m_tlast", m_tlast, 0);
    chk("idle_grant", grant, 0);
    chk("idle_err_tk", err_tlast_tkeep, 0);
    chk("idle_err_und", err_underrun, 0);
    chk("idle_s_tready", s_tready, 0);
    // 4-beat packet from port 2
    base = on;
    ib = inn;
    load(2, 1, 4, 16'hFFFF, -1, 0);
    wait_out(base + 4, 20);
    chk("t1_latency", out_c[base], in_c[ib] + 1);
    chk("t1_grant_first", in_g[ib], 0);
    for (int b = 0; b < 4; b++) begin
      chk("t1_beat", out_b[base + b], {mk(2, 1, b), 16'hFFFF, b == 3});
      chk("t1_nogap", out_c[base + b], out_c[base] + b);
      if (b > 0) chk("t1_grant", in_g[ib + b], 4'b0100);
    end
    step(2);
    chk("t1_rr_ptr", dut.rr_ptr, 2);
    // all ports busy with 3-beat packets: strict rotation, no gaps
    do_reset();
    base = on;
    for (int n = 0; n < 2; n++)
      for (int p = 0; p < NP; p++) load(p, n, 3, 16'hFFFF, -1, 0);
    wait_out(base + 24, 80);
    for (int i = 0; i < 24; i++) begin
      k = i / 3;
      chk("t2_beat", out_b[base + i], {mk(k % 4, k / 4, i % 3), 16'hFFFF, (i % 3) == 2});
      chk("t2_nogap", out_c[base + i], out_c[base] + i);
    end
    // 10-beat packet under random-looking backpressure
    do_reset();
    base = on;
    load(1, 0, 10, 16'h003F, -1, 0);
    t = 0;
    while (on < base + 10 && t < 100) begin
      m_tready = pat[4'(t)];
      step(1);
      t++;
    end
    m_tready = 1'b1;
    chk("t3_timeout", on >= base + 10, 1);
    for (int b = 0; b < 10; b++)
      chk("t3_beat", out_b[base + b], {mk(1, 0, b), (b == 9) ? 16'h003F : 16'hFFFF, b == 9});
    step(3);
    chk("t3_no_dup", on, base + 10);
    // simultaneous single-beat packets on ports 1 and 3
    do_reset();
    base = on;
    g0 = n_gnz;
    load(1, 0, 1, 16'h00FF, -1, 0);
    load(3, 0, 1, 16'h00FF, -1, 0);
    wait_out(base + 2, 20);
    chk("t4_first", out_b[base], {mk(1, 0, 0), 16'h00FF, 1'b1});
    chk("t4_second", out_b[base + 1], {mk(3, 0, 0), 16'h00FF, 1'b1});
    chk("t4_nogap", out_c[base + 1], out_c[base] + 1);
    step(2);
    chk("t4_stay_idle", n_gnz - g0, 0);
    chk("t4_rr_ptr", dut.rr_ptr, 3);
    // underrun mid-packet, then a tlast beat with empty keep
    do_reset();
    base = on;
    u0 = n_und;
    k0 = n_tk;
    h0 = n_hold0;
    load(0, 0, 5, 16'hFFFF, 2, 2);
    load(2, 0, 2, 16'hFFFF, -1, 0);
    load(3, 0, 1, 16'h0000, -1, 0);
    wait_out(base + 8, 40);
    for (int b = 0; b < 5; b++) chk("t5_p0", out_b[base + b], {mk(0, 0, b), 16'hFFFF, b == 4});
    for (int b = 0; b < 2; b++) chk("t5_p2", out_b[base + 5 + b], {mk(2, 0, b), 16'hFFFF, b == 1});
    chk("t5_p3", out_b[base + 7], {mk(3, 0, 0), 16'h0000, 1'b1});
    step(2);
    chk("t5_underrun_cycles", n_und - u0, 2);
    chk("t5_grant_held", n_hold0 - h0, 2);
    chk("t5_tlast_tkeep", n_tk - k0, 1);
    // reset on the third beat of a 6-beat packet
    do_reset();
    r0 = rd[1];
    load(1, 0, 6, 16'hFFFF, -1, 0);
    t = 0;
    while (rd[1] < r0 + 2 && t < 20) begin
      step(1);
      t++;
    end
    chk("t6_pre_valid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", m_tvalid, 0);
    chk("t6_async_ready", s_tready, 0);
    chk("t6_async_grant", grant, 0);
    for (int p = 0; p < NP; p++) wr[p] = rd[p];
    step(2);
    rst = 1'b0;
    step(1);
    base = on;
    load(1, 1, 1, 16'hFFFF, -1, 0);
    load(0, 1, 1, 16'hFFFF, -1, 0);
    wait_out(base + 2, 20);
    chk("t6_port0_first", out_b[base], {mk(0, 1, 0), 16'hFFFF, 1'b1});
    chk("t6_port1_next", out_b[base + 1], {mk(1, 1, 0), 16'hFFFF, 1'b1});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
